tdm_demux: RTL
==============

Name: tdm_demux

Overview:
Receive end of the time-division-multiplexed select path. A single shared data line carries one channel sample per slot, and a sync marker flags slot 0 of each frame. The block locks to frames, gathers NUM_CH channel samples into a shadow register, and publishes the whole frame atomically on parallel outputs. It sits between the top-level pin wrapper and downstream consumers.

Parameters:
NUM_CH, 8, number of channels (slots) per frame; must be at least 2
W, 1, bits per channel sample

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  sample strobe; din and sync are valid only when en=1
sync  input  1  frame marker; qualified by en; marks slot 0
din  input  W  channel sample for the current slot
ch_out  output  NUM_CH*W  last complete frame; channel k occupies bits [k*W +: W]
frame_valid  output  1  one-cycle pulse when ch_out updates
sync_err  output  1  one-cycle pulse on a framing violation
locked  output  1  high while in LOCKED state

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst=1: state=HUNT, slot=0, shadow=0, ch_out=0, frame_valid=0, sync_err=0, locked=0.
- State machine has two states, HUNT and LOCKED. All outputs are registered.
- In HUNT, en=0 or sync=0:
  - Samples are ignored. No error is raised.
- In HUNT, en=1 and sync=1:
  - shadow[0] <= din; slot <= 1; next state = LOCKED.
- In LOCKED, en=1, sync=0, and slot between 1 and NUM_CH-1:
  - shadow[slot] <= din.
  - If slot = NUM_CH-1: ch_out <= shadow with din written into the last position; frame_valid=1 next cycle; slot <= 0.
  - Otherwise slot <= slot+1.
- In LOCKED, en=1, sync=1, slot=0:
  - shadow[0] <= din; slot <= 1. This is the normal frame start.
- In LOCKED, en=1, sync=1, slot not 0 (early sync):
  - sync_err=1 next cycle. The partial frame is discarded and ch_out is unchanged.
  - The current sample is taken as slot 0: shadow[0] <= din; slot <= 1. State stays LOCKED.
- In LOCKED, en=1, sync=0, slot=0 (missing sync):
  - sync_err=1 next cycle; the sample is discarded; slot <= 0; next state = HUNT.
- en=0: no state, slot, or shadow change. Any number of idle cycles between samples is legal.
- Latency: ch_out and frame_valid update on the clock edge after the cycle that carries the last-slot sample.
- ch_out holds its value until the next complete frame. Partial frames never reach ch_out.
- frame_valid and sync_err never assert in the same cycle. Each is high for exactly one cycle per event.
- locked is 1 on the cycle after entering LOCKED and drops on the cycle after returning to HUNT.
- rst asserted mid-frame: the partial frame is lost, all outputs go to 0 immediately, and the block restarts in HUNT.
- Slot counter width is clog2(NUM_CH). The counter never exceeds NUM_CH-1. Wrap to 0 is explicit, not modular overflow.

Decomposition:
- Shared package holds:
  - state enum {HUNT, LOCKED};
  - a clog2-based slot-index width constant/function;
  - the default channel count.
- Sub-module tdm_slot_counter: holds the slot index with load-to-1, increment, and clear-on-last. It outputs a slot index and last_slot flag.
- Shadow/output registers and the FSM stay in tdm_demux.

Test Plan:
1. Reset then clean frame. Defaults, one en pulse per cycle, sync on the first sample, din = 1,0,1,1,0,0,1,0 → ch_out=8'h4D and frame_valid=1 for one cycle, one clock after the 8th sample. locked=1 from the second cycle onward.
2. Gapped strobes. The same frame with 0–3 idle en=0 cycles between samples → identical ch_out=8'h4D, a single frame_valid pulse, sync_err never asserted.
3. Early sync. Sync on the first sample; after 5 samples, sync again; then 7 more samples of 1 → sync_err pulse after the early-sync sample, no frame_valid for the aborted frame, then ch_out=8'hFF with din=1 on the resync sample.
4. Missing sync. A valid frame 8'h4D, then a sample with en=1 and sync=0 at slot 0 → sync_err pulse, locked=0 next cycle, ch_out stays 8'h4D. Subsequent non-sync samples are ignored until the next sync.
5. Async reset mid-frame. Assert rst after 4 samples, between clock edges → ch_out=0, locked=0, and frame_valid=0 immediately without waiting for clk. After release, a full frame 8'hA5 decodes correctly.
6. Back-to-back frames. Frames 8'h01 then 8'h80 with no idle cycles → two frame_valid pulses exactly 8 cycles apart and ch_out values in order.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing helpers for the TDM receive path.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_CH = 8;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index within a frame: load-to-1 on frame start, increment, explicit wrap on last slot.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned SW     = slot_w(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load1,
    input  logic          inc,
    input  logic          clear,
    output logic [SW-1:0] slot,
    output logic          last_slot
);

    localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

    assign last_slot = (slot == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= last_slot ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Frame-locked TDM demultiplexer: gathers NUM_CH slot samples and publishes
// each complete frame atomically on ch_out.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned W      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic [W-1:0]        din,
    output logic [NUM_CH*W-1:0] ch_out,
    output logic                frame_valid,
    output logic                sync_err,
    output logic                locked
);

    localparam int unsigned SW = slot_w(NUM_CH);

    state_t                    state, next_state;
    logic [SW-1:0]             slot;
    logic                      last_slot;
    // The last slot goes straight from din into ch_out, so it has no shadow entry.
    logic [NUM_CH-2:0][W-1:0]  shadow;
    logic [NUM_CH-1:0][W-1:0]  frame;
    logic                      load1, inc, clear, publish, err;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .SW     (SW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load1     (load1),
        .inc       (inc),
        .clear     (clear),
        .slot      (slot),
        .last_slot (last_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (en) begin
            case (state)
                HUNT:    if (sync) next_state = LOCKED;
                LOCKED:  if (!sync && slot == '0) next_state = HUNT;
                default: next_state = HUNT;
            endcase
        end
    end

    always_comb begin
        load1   = 1'b0;
        inc     = 1'b0;
        clear   = 1'b0;
        publish = 1'b0;
        err     = 1'b0;
        frame   = {din, shadow};
        if (en) begin
            case (state)
                HUNT: load1 = sync;
                LOCKED: begin
                    if (sync) begin
                        load1 = 1'b1;
                        err   = (slot != '0);
                    end else if (slot == '0) begin
                        clear = 1'b1;
                        err   = 1'b1;
                    end else begin
                        inc     = 1'b1;
                        publish = last_slot;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            ch_out      <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= publish;
            sync_err    <= err;
            if (load1)
                shadow[0] <= din;
            else if (inc && !last_slot)
                shadow[slot] <= din;
            if (publish)
                ch_out <= frame;
        end
    end

    assign locked = (state == LOCKED);

endmodule
